// File: rtl/mul_pkg.sv
// Shared types and sizing helpers for the sequential multiply-accumulate block.
package mul_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    function automatic int unsigned acc_width(input int unsigned width,
                                              input int unsigned guard);
        return 2 * width + guard;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/cond_negate.sv
// Conditional two's-complement negation: y = neg ? -x : x.
module cond_negate #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] x,
    input  logic         neg,
    output logic [N-1:0] y
);

    assign y = neg ? -x : x;

endmodule

// File: rtl/seq_mul_acc.sv
// Sequential shift-add multiplier with optional accumulate, valid/ready on both sides.
// One multiplier bit per cycle on operand magnitudes; sign is applied once at the end.
module seq_mul_acc
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ACC_GUARD = 4
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [WIDTH-1:0]                        a,
    input  logic [WIDTH-1:0]                        b,
    input  logic                                    signed_op,
    input  logic                                    acc_op,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [acc_width(WIDTH, ACC_GUARD)-1:0]  result
);

    localparam int unsigned AW = acc_width(WIDTH, ACC_GUARD);
    localparam int unsigned CW = cnt_width(WIDTH);
    localparam int unsigned PW = 2 * WIDTH;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d, mult_q, mult_d, a_mag, b_mag;
    logic             neg_q, neg_d, sgn_q, sgn_d, acc_q, acc_d;
    logic [PW-1:0]    p_q, p_d, p_next, prod;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    result_q, result_d, prod_ext;

    cond_negate #(.N(WIDTH)) u_mag_a (
        .x   (a),
        .neg (signed_op & a[WIDTH-1]),
        .y   (a_mag)
    );

    cond_negate #(.N(WIDTH)) u_mag_b (
        .x   (b),
        .neg (signed_op & b[WIDTH-1]),
        .y   (b_mag)
    );

    // Multiplier is shifted right each cycle, so bit 0 is always the current bit.
    assign p_next = mult_q[0] ? p_q + (PW'(mcand_q) << cnt_q) : p_q;

    cond_negate #(.N(PW)) u_prod (
        .x   (p_next),
        .neg (neg_q),
        .y   (prod)
    );

    assign prod_ext = sgn_q ? AW'($signed(prod)) : AW'(prod);

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mult_d   = mult_q;
        neg_d    = neg_q;
        sgn_d    = sgn_q;
        acc_d    = acc_q;
        p_d      = p_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d = a_mag;
                    mult_d  = b_mag;
                    neg_d   = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                    sgn_d   = signed_op;
                    acc_d   = acc_op;
                    p_d     = '0;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                p_d    = p_next;
                mult_d = mult_q >> 1;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    result_d = acc_q ? result_q + prod_ext : prod_ext;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mult_q   <= '0;
            neg_q    <= 1'b0;
            sgn_q    <= 1'b0;
            acc_q    <= 1'b0;
            p_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mult_q   <= mult_d;
            neg_q    <= neg_d;
            sgn_q    <= sgn_d;
            acc_q    <= acc_d;
            p_q      <= p_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;

endmodule
